// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer for a single-bit ALU slice: latches operands and opcode,
// feeds one bit pair per clock LSB first, and assembles the returned result bits.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_op,
    input  logic             slice_out,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [1:0]       op_lat;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             accept;
    logic             arith;
    logic             last_bit;

    assign accept   = start && (state != RUN);
    assign arith    = op_lat[1];
    assign last_bit = (idx == LAST_IDX);
    assign slice_op = op_lat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_cin  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                slice_a   = a_lat[idx];
                slice_b   = b_lat[idx] ^ (op_lat == OP_SUB);
                slice_cin = carry;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Logic ops keep the carry chain at zero so a stray slice carry never leaks out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_lat     <= '0;
            b_lat     <= '0;
            op_lat    <= 2'b00;
            idx       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_lat     <= A;
            b_lat     <= B;
            op_lat    <= op;
            idx       <= '0;
            carry     <= (op == OP_SUB);
            result    <= '0;
            carry_out <= 1'b0;
        end else if (state == RUN) begin
            result[idx] <= slice_out;
            carry       <= arith ? slice_cout : 1'b0;
            if (last_bit) begin
                carry_out <= arith ? slice_cout : 1'b0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq with a behavioural one-bit slice and
// a word-level arithmetic reference model.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         slice_a;
    logic         slice_b;
    logic         slice_cin;
    logic [1:0]   slice_op;
    logic         slice_out;
    logic         slice_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .A          (A),
        .B          (B),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_op   (slice_op),
        .slice_out  (slice_out),
        .slice_cout (slice_cout),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out)
    );

    always #5 clk = ~clk;

    // Behavioural slice; the logic ops return a deliberately nonzero carry.
    always_comb begin
        case (slice_op)
            2'b00:   begin slice_out = slice_a & slice_b; slice_cout = slice_a | slice_b; end
            2'b01:   begin slice_out = slice_a | slice_b; slice_cout = slice_a | slice_b; end
            default: begin
                slice_out  = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
            end
        endcase
    end

    function automatic logic [W:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        case (o)
            2'b00:   r = {1'b0, a & b};
            2'b01:   r = {1'b0, a | b};
            2'b10:   r = {1'b0, a} + {1'b0, b};
            default: r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from an idle bench; lat counts cycles from the start edge to done.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt, output logic [W-1:0] res,
                         output logic co, output logic cin_first);
        int cyc;
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0;
        cyc = 1; busy_cnt = 0; cin_first = 1'bx;
        while (done !== 1'b1 && cyc < 30) begin
            if (busy === 1'b1) busy_cnt++;
            if (cyc == 1) cin_first = slice_cin;
            tick();
            cyc++;
        end
        lat = cyc; res = result; co = carry_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = 2'b11; A = 8'hFF; B = 8'hFF;
        tick(); tick();
        start = 1'b0;
        n_cmp++;
        if ({busy, done, carry_out, slice_a, slice_b, slice_cin} !== 6'b0 || result !== 8'h00 || slice_op !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_state: busy=%b done=%b result=%h co=%b sa=%b sb=%b cin=%b sop=%b required all zero",
                     busy, done, result, carry_out, slice_a, slice_b, slice_cin, slice_op);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_overrides_start: busy=%b required 0", busy);
        end
    endtask

    task automatic test_directed();
        int lat, bc; logic [W-1:0] res; logic co, cf;
        logic [1:0] ops [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        logic [W-1:0] as [5] = '{8'hA5, 8'hFF, 8'h12, 8'h05, 8'h07};
        logic [W-1:0] bs [5] = '{8'h0F, 8'h01, 8'h34, 8'h07, 8'h05};
        logic [W-1:0] er [5] = '{8'hAF, 8'h00, 8'h46, 8'hFE, 8'h02};
        logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], lat, bc, res, co, cf);
            n_cmp++;
            if (lat !== W + 1 || bc !== W) begin
                n_fail++;
                $display("[TB] FAIL directed_timing[%0d]: latency=%0d busy=%0d required %0d/%0d", i, lat, bc, W + 1, W);
            end
            n_cmp++;
            if (res !== er[i] || co !== ec[i]) begin
                n_fail++;
                $display("[TB] FAIL directed_result[%0d]: got %h/%b required %h/%b", i, res, co, er[i], ec[i]);
            end
            if (ops[i] == 2'b11) begin
                n_cmp++;
                if (cf !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL sub_first_cin[%0d]: got %b required 1", i, cf);
                end
            end
            tick();
            n_cmp++;
            if (done !== 1'b0 || result !== er[i]) begin
                n_fail++;
                $display("[TB] FAIL directed_hold[%0d]: done=%b result=%h required 0/%h", i, done, result, er[i]);
            end
        end
    endtask

    task automatic test_idle_outputs();
        int lat, bc; logic [W-1:0] res; logic co, cf;
        do_op(2'b10, 8'hFF, 8'hFF, lat, bc, res, co, cf);
        tick();
        n_cmp++;
        if (slice_a !== 1'b0 || slice_b !== 1'b0 || slice_cin !== 1'b0 || slice_op !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL idle_slice: sa=%b sb=%b cin=%b sop=%b required 0/0/0/10", slice_a, slice_b, slice_cin, slice_op);
        end
    endtask

    task automatic test_random();
        int lat, bc; logic [W-1:0] res; logic co, cf;
        logic [1:0] o; logic [W-1:0] a, b; logic [W:0] exp_v;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            exp_v = ref_model(o, a, b);
            do_op(o, a, b, lat, bc, res, co, cf);
            n_cmp++;
            if (lat !== W + 1 || res !== exp_v[W-1:0] || co !== exp_v[W]) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] op=%b a=%h b=%h: got %h/%b lat %0d required %h/%b lat %0d",
                         i, o, a, b, res, co, lat, exp_v[W-1:0], exp_v[W], W + 1);
            end
            tick();
        end
    endtask

    task automatic test_start_ignored();
        int cyc; int dones;
        start = 1'b1; op = 2'b00; A = 8'hF0; B = 8'h3C;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; op = 2'b01; A = 8'hFF; B = 8'hFF;
        tick();
        start = 1'b0;
        cyc = 4;
        while (done !== 1'b1 && cyc < 30) begin tick(); cyc++; end
        n_cmp++;
        if (cyc !== W + 1 || result !== 8'h30 || carry_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL start_ignored: lat=%0d result=%h co=%b required %0d/30/0", cyc, result, carry_out, W + 1);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_fail++;
            $display("[TB] FAIL start_ignored_extra: extra activity cycles=%0d required 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        start = 1'b1; op = 2'b10; A = 8'h77; B = 8'h19;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || result !== 8'h00 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: busy=%b result=%h done=%b required 0/00/0", busy, result, done);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_done: done pulses=%0d required 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; int t1; int t2;
        start = 1'b1; op = 2'b01; A = 8'hA5; B = 8'h0F;
        tick();
        cyc = 1;
        while (done !== 1'b1 && cyc < 30) begin tick(); cyc++; end
        t1 = cyc;
        n_cmp++;
        if (result !== 8'hAF || carry_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got %h/%b required AF/0", result, carry_out);
        end
        op = 2'b10; A = 8'hC8; B = 8'h64;
        tick();
        start = 1'b0;
        cyc++;
        while (done !== 1'b1 && cyc < 60) begin tick(); cyc++; end
        t2 = cyc;
        n_cmp++;
        if (t2 - t1 !== W + 1 || result !== 8'h2C || carry_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: gap=%0d got %h/%b required %0d 2C/1", t2 - t1, result, carry_out, W + 1);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        test_reset();
        test_directed();
        test_idle_outputs();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial sequencer that drives the single-bit ALU slice. It latches two WIDTH-bit operands and an opcode, presents one operand bit pair per clock (LSB first) to the slice's inputs, and carries the slice's carry between bits. It shifts each returned result bit into a WIDTH-bit result register and reports completion with a one-cycle `done` pulse. It sits directly upstream of the slice (it feeds A/B/carry-in) and also consumes the slice's out/carry-out.

## Interface
- `WIDTH`, default 8, operand/result width in bits (≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  request a new operation; accepted only in IDLE or DONE.
- `op`  in  2  00 AND, 01 OR, 10 ADD, 11 SUB (A−B); sampled with accepted `start`.
- `A`  in  WIDTH  operand A; sampled with accepted `start`.
- `B`  in  WIDTH  operand B; sampled with accepted `start`.
- `slice_a`  out  1  current A bit to the slice.
- `slice_b`  out  1  current B bit to the slice; inverted for SUB.
- `slice_cin`  out  1  carry into the slice.
- `slice_op`  out  2  opcode to the slice; equals the latched `op`.
- `slice_out`  in  1  slice result bit; combinational from `slice_*`.
- `slice_cout`  in  1  slice carry-out; combinational.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last bit is captured.
- `result`  out  WIDTH  assembled result; held stable until the next accepted `start`.
- `carry_out`  out  1  final carry for ADD/SUB (SUB: 1 = no borrow); 0 for AND/OR.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1:
  - Latch `A`, `B`, `op`.
  - Bit index ← 0; carry ← 1 if op=SUB, else 0.
  - Clear `result` and `carry_out`.
  - Go to RUN.
- IDLE/DONE with `start`=0:
  - IDLE stays in IDLE.
  - DONE returns to IDLE.
- RUN, each cycle at bit index i:
  - `slice_a` = A_lat[i].
  - `slice_b` = B_lat[i] XOR (op=SUB).
  - `slice_cin` = carry register.
  - At the clock edge: result[i] ← `slice_out`.
  - For ADD/SUB: carry ← `slice_cout`. For AND/OR: carry held 0.
  - i ← i+1.
- RUN, when i = WIDTH−1:
  - After capture, `carry_out` ← `slice_cout` (ADD/SUB) or 0 (AND/OR).
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle. Then IDLE, unless `start` is accepted, which goes straight to RUN.
- `start` is ignored while in RUN; latched operands are not disturbed.
- Outside RUN, `slice_a`, `slice_b`, `slice_cin` are 0 and `slice_op` holds its last value.
- Bit index is ⌈log2 WIDTH⌉ bits wide and never wraps past WIDTH−1.
- Arithmetic is modulo 2^WIDTH. There is no overflow flag.

## Timing
- Reset (`rst_n`=0 at a rising edge), all outputs:
  - State = IDLE.
  - `busy`=0, `done`=0.
  - `result`=0, `carry_out`=0.
  - `slice_a`=`slice_b`=`slice_cin`=0.
  - `slice_op`=00.
- Reset overrides `start`.
- Reset mid-RUN aborts the operation. No `done` pulse is produced and partial results are discarded.
- Latency, with `start` accepted at edge T:
  - RUN occupies cycles T+1 … T+WIDTH (`busy`=1).
  - `done`=1 in cycle T+WIDTH+1, with `result`/`carry_out` valid.
- Throughput: with `start` held high in DONE, one operation per WIDTH+1 cycles.
- The slice is combinational. Bit i's `slice_out` is captured at the same edge that advances i.

## Test plan
- OR, A=8'hA5, B=8'h0F, WIDTH=8 → `done` 9 cycles after `start`, `result`=8'hAF, `carry_out`=0; `busy` high for exactly 8 cycles.
- ADD, A=8'hFF, B=8'h01 → `result`=8'h00, `carry_out`=1. Then ADD 8'h12+8'h34 → 8'h46, `carry_out`=0.
- SUB, A=8'h05, B=8'h07 → `result`=8'hFE, `carry_out`=0. SUB 8'h07−8'h05 → 8'h02, `carry_out`=1. `slice_cin`=1 on the first RUN cycle.
- Start ignored while busy: AND 8'hF0&8'h3C started, then `start` with new operands in RUN cycle 3 → `result`=8'h30; no extra operation and no second `done`.
- Reset mid-op: ADD started, `rst_n`=0 in RUN cycle 4 → next cycle `busy`=0, `result`=0; no `done` pulse follows.
- Back-to-back: `start` held high with OR then ADD operands switched at DONE → two `done` pulses 9 cycles apart, each with the correct result.
